// File: rtl/add_seq_master_pkg.sv
// Shared constants and state encoding for the sequenced adder master.
package add_seq_master_pkg;

  localparam logic [2:0] ADDR_A   = 3'd0;
  localparam logic [2:0] ADDR_B   = 3'd1;
  localparam logic [2:0] ADDR_SUM = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    RD,
    WAIT_RD,
    DONE
  } state_e;

endpackage

// File: rtl/add_seq_master.sv
// Avalon-MM master: writes an operand pair to an adder slave,
// reads back the sum and hands it out on a valid/ready port.
module add_seq_master
  import add_seq_master_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [2:0]       avm_address,
  output logic             avm_write,
  output logic             avm_read,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_waitrequest,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        sum_q, sum_d;
  logic [2:0]         lat_q, lat_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      lat_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      lat_q   <= lat_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    sum_d         = sum_q;
    lat_d         = lat_q;
    cnt_d         = cnt_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_address   = ADDR_A;
    avm_writedata = '0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = WR_A;
        end
      end
      WR_A: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_A;
        avm_writedata = a_q;
        if (!avm_waitrequest) state_d = WR_B;
      end
      WR_B: begin
        avm_write     = 1'b1;
        avm_address   = ADDR_B;
        avm_writedata = b_q;
        if (!avm_waitrequest) state_d = RD;
      end
      RD: begin
        avm_read    = 1'b1;
        avm_address = ADDR_SUM;
        if (!avm_waitrequest) begin
          lat_d   = '0;
          state_d = WAIT_RD;
        end
      end
      // Slave has no stall once the read is accepted; waitrequest ignored.
      WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          sum_d   = avm_readdata;
          lat_d   = '0;
          state_d = DONE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_d   = cnt_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_sum    = sum_q;
  assign done_count = cnt_q;

endmodule

// File: doc/add_seq_master.md
ADD_SEQ_MASTER -- requirements
Module: add_seq_master

Interface
REQ-001 Parameter READ_LATENCY, default 1, fixed slave read latency in cycles (1..4).
REQ-002 Parameter CNT_W, default 16, width of the completed-operation counter.
REQ-003 clock  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair valid.
REQ-006 in_ready  out  1  block accepts operand pair.
REQ-007 in_a  in  32  operand A.
REQ-008 in_b  in  32  operand B.
REQ-009 out_valid  out  1  sum valid.
REQ-010 out_ready  in  1  consumer accepts sum.
REQ-011 out_sum  out  32  sum read back from the adder slave.
REQ-012 avm_address  out  3  Avalon-MM master address.
REQ-013 avm_write  out  1  write strobe.
REQ-014 avm_read  out  1  read strobe.
REQ-015 avm_writedata  out  32  write data.
REQ-016 avm_readdata  in  32  read data, valid exactly READ_LATENCY cycles after an accepted read.
REQ-017 avm_waitrequest  in  1  slave stall; tie 0 for slaves without stall.
REQ-018 done_count  out  CNT_W  completed operations, wraps modulo 2^CNT_W.

Function
REQ-019 FSM states: IDLE, WR_A, WR_B, RD, WAIT_RD, DONE.
REQ-020 IDLE: in_ready=1; on in_valid, latch in_a/in_b and go to WR_A.
REQ-021 in_ready SHALL be 1 only in IDLE; no operand is accepted in any other state.
REQ-022 WR_A: avm_write=1, avm_address=ADDR_A (0), avm_writedata=latched A; advance to WR_B when avm_waitrequest=0, else hold all outputs.
REQ-023 WR_B: avm_write=1, avm_address=ADDR_B (1), avm_writedata=latched B; advance to RD when avm_waitrequest=0.
REQ-024 RD: avm_read=1, avm_address=ADDR_SUM (3); advance to WAIT_RD when avm_waitrequest=0.
REQ-025 WAIT_RD: count READ_LATENCY cycles after the accepted read; in the final counted cycle sample avm_readdata into out_sum and go to DONE.
REQ-026 DONE: out_valid=1, out_sum stable; on out_ready go to IDLE and increment done_count.
REQ-027 avm_read and avm_write SHALL never be high in the same cycle; both are 0 outside WR_A/WR_B/RD.
REQ-028 With waitrequest=0, READ_LATENCY=1 and in_valid accepted in cycle 0: WR_A cycle 1, WR_B cycle 2, RD cycle 3, out_valid in cycle 5.
REQ-029 Sum is the slave's 32-bit result; the carry-out is discarded (modulo 2^32).
REQ-030 out_ready asserted while out_valid=0 SHALL have no effect; out_valid held indefinitely while out_ready=0.
REQ-031 avm_waitrequest in WAIT_RD or DONE SHALL be ignored.

Reset
REQ-032 reset SHALL win over every other input in the same cycle.
REQ-033 On reset: state=IDLE, in_ready=1 (IDLE), out_valid=0, out_sum=0, done_count=0, avm_write=0, avm_read=0, avm_address=0, avm_writedata=0, latency counter=0.
REQ-034 Reset mid-transaction SHALL abandon it with no further bus cycles and no out_valid.

Structure
REQ-035 Shared package holds ADDR_A=3'd0, ADDR_B=3'd1, ADDR_SUM=3'd3 and the state enumeration.
REQ-036 No sub-module; single module with FSM, operand latch, latency counter and output register.

Verification
REQ-037 in_a=5, in_b=7, out_ready=1 -> writes 5@0, 7@1, read@3, out_sum=12 in cycle 5, done_count=1.
REQ-038 in_a=0xFFFFFFFF, in_b=1 -> out_sum=0x00000000 (carry dropped).
REQ-039 out_ready=0 for 3 cycles after out_valid -> out_valid and out_sum held, in_ready=0, no bus activity, completion on 4th cycle.
REQ-040 avm_waitrequest=1 for 2 cycles during WR_B -> avm_write/avm_address=1/avm_writedata held, result delayed by 2 cycles.
REQ-041 reset asserted in WAIT_RD -> next cycle IDLE, out_valid never asserts, done_count unchanged at 0.
REQ-042 Back-to-back pairs (1,2),(3,4) with in_valid held -> sums 3 then 7 in order, second accepted the cycle after first out handshake.
